cust_queue: RTL and testbench
=============================

CUST_QUEUE -- requirements
Module: cust_queue

Interface
REQ-001 SHALL have parameter DT_SZ, default 4, service-time width in ticks.
REQ-002 SHALL have parameter NUM_SZ, default 4, ticket-number width.
REQ-003 SHALL have parameter DEPTH, default 8, waiting-line capacity; power of two, at least 2.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port arr  in  1  customer-arrival strobe, one cycle per customer.
REQ-007 SHALL have port arr_dt  in  DT_SZ  service time of arriving customer.
REQ-008 SHALL have port cnt_busy  in  1  busy flag from the downstream service counter.
REQ-009 SHALL have port ld  out  1  load strobe to the counter.
REQ-010 SHALL have port dn  out  NUM_SZ  ticket number presented with ld.
REQ-011 SHALL have port dt  out  DT_SZ  service time presented with ld.
REQ-012 SHALL have port full  out  1  queue holds DEPTH entries.
REQ-013 SHALL have port empty  out  1  queue holds 0 entries.
REQ-014 SHALL have port q_cnt  out  $clog2(DEPTH+1)  waiting-customer count.
REQ-015 SHALL have port tkt  out  NUM_SZ  next ticket number to be issued.
REQ-016 SHALL have port drop  out  1  one-cycle pulse: arrival rejected.

Function
REQ-017 SHALL accept an arrival when arr=1, arr_dt!=0, and either q_cnt<DEPTH or a pop occurs in the same cycle.
REQ-018 SHALL, on acceptance, push {tkt, arr_dt} at the tail and increment tkt; tkt wraps from 2^NUM_SZ-1 to 1, never 0.
REQ-019 SHALL reject an arrival when arr_dt==0 or the queue is full with no same-cycle pop: no push, tkt unchanged, drop=1 in the following cycle.
REQ-020 SHALL implement FSM states IDLE, LOAD, ACK, SERV.
REQ-021 SHALL transition IDLE->LOAD when empty==0 and cnt_busy==0, otherwise remain in IDLE.
REQ-022 SHALL, in LOAD, hold for exactly one cycle: ld=1, dn/dt=head entry, head popped; then go to ACK.
REQ-023 SHALL, in ACK, go to SERV on cnt_busy=1, or to IDLE after 2 cycles without cnt_busy (no reissue of the popped entry).
REQ-024 SHALL, in SERV, go to IDLE on cnt_busy=0.
REQ-025 SHALL register ld, dn, dt; dn=0 and dt=0 whenever ld=0.
REQ-026 SHALL give latency: arrival captured at edge k into an empty queue with the counter idle -> ld high from edge k+1 to edge k+2.
REQ-027 SHALL update q_cnt/full/empty on the same edge as push/pop; simultaneous push+pop leaves q_cnt unchanged.
REQ-028 SHALL serve entries strictly FIFO; pointers wrap modulo DEPTH.

Reset
REQ-029 SHALL, on rst_n=0, immediately force state=IDLE, ld=0, dn=0, dt=0, drop=0, q_cnt=0, empty=1, full=0, tkt=1, pointers=0.
REQ-030 SHALL, on reset mid-operation, discard all queued customers and any in-flight load.

Structure
REQ-031 SHALL place the FSM state enum and default DT_SZ/NUM_SZ/DEPTH constants in shared package cust_pkg.
REQ-032 SHALL instantiate one sub-module cust_fifo (synchronous FIFO, width NUM_SZ+DT_SZ, depth DEPTH, with count output).

Verification
REQ-033 SHALL cover: arr with arr_dt=3 while idle, counter idle -> ld one cycle at edge k+1, dn=1, dt=3; tkt=2.
REQ-034 SHALL cover: 3 arrivals (dt=3,6,2) while cnt_busy=1 -> q_cnt=3; on release, loads dn=1,2,3 in order, each only after cnt_busy falls.
REQ-035 SHALL cover: 9 arrivals with DEPTH=8, counter busy -> full=1, 9th gives drop=1, tkt=9.
REQ-036 SHALL cover: arrival with arr_dt=0 -> drop=1, q_cnt and tkt unchanged.
REQ-037 SHALL cover: tkt=15 (NUM_SZ=4), two arrivals -> dn=15 then dn=1.
REQ-038 SHALL cover: rst_n low while SERV with q_cnt=4 -> all outputs at reset values; no ld after rst_n rises until a new arrival.

Source files
------------

// File: rtl/cust_pkg.sv
// Shared types and default sizes for the customer queue and its FIFO.
package cust_pkg;

    localparam int unsigned DT_SZ_DEF  = 4;
    localparam int unsigned NUM_SZ_DEF = 4;
    localparam int unsigned DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2,
        SERV = 2'd3
    } state_t;

endpackage

// File: rtl/cust_fifo.sv
// Synchronous FIFO with registered occupancy count and full/empty flags.
module cust_fifo
    import cust_pkg::*;
#(
    parameter  int unsigned WIDTH = NUM_SZ_DEF + DT_SZ_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en_c;
    logic             rd_en_c;
    logic [CW-1:0]    count_nxt_c;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign rd_en_c   = pop && !empty;
    assign wr_en_c   = push && (!full || rd_en_c);
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_nxt_c = count;
        if (wr_en_c && !rd_en_c) begin
            count_nxt_c = count + CW'(1);
        end else if (!wr_en_c && rd_en_c) begin
            count_nxt_c = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CW'(DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

endmodule

// File: rtl/cust_queue.sv
// Customer waiting line: issues tickets, queues arrivals and hands them
// one at a time to a downstream service counter.
module cust_queue
    import cust_pkg::*;
#(
    parameter  int unsigned DT_SZ  = DT_SZ_DEF,
    parameter  int unsigned NUM_SZ = NUM_SZ_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned CW     = $clog2(DEPTH + 1),
    localparam int unsigned EW     = NUM_SZ + DT_SZ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arr,
    input  logic [DT_SZ-1:0]  arr_dt,
    input  logic              cnt_busy,
    output logic              ld,
    output logic [NUM_SZ-1:0] dn,
    output logic [DT_SZ-1:0]  dt,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     q_cnt,
    output logic [NUM_SZ-1:0] tkt,
    output logic              drop
);

    state_t            state;
    state_t            state_nxt_c;
    logic              ack_cnt;
    logic              ack_cnt_nxt_c;
    logic              load_c;
    logic              pop_c;
    logic              accept_c;
    logic              reject_c;
    logic [EW-1:0]     head_c;
    logic [NUM_SZ-1:0] head_num_c;
    logic [DT_SZ-1:0]  head_dt_c;
    logic [NUM_SZ-1:0] tkt_nxt_c;

    cust_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept_c),
        .wr_data   ({tkt, arr_dt}),
        .pop       (pop_c),
        .rd_data_c (head_c),
        .full      (full),
        .empty     (empty),
        .count     (q_cnt)
    );

    assign head_num_c = head_c[EW-1:DT_SZ];
    assign head_dt_c  = head_c[DT_SZ-1:0];

    // Zero service time is never queued; a full line accepts only alongside a pop.
    assign accept_c  = arr && (arr_dt != '0) && (!full || pop_c);
    assign reject_c  = arr && !accept_c;
    assign tkt_nxt_c = (tkt == '1) ? NUM_SZ'(1) : tkt + NUM_SZ'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ack_cnt <= 1'b0;
        end else begin
            state   <= state_nxt_c;
            ack_cnt <= ack_cnt_nxt_c;
        end
    end

    // ACK waits two cycles for the counter to react; a timeout drops the entry.
    always_comb begin
        state_nxt_c   = state;
        ack_cnt_nxt_c = 1'b0;
        load_c        = 1'b0;
        pop_c         = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !cnt_busy) begin
                    state_nxt_c = LOAD;
                    load_c      = 1'b1;
                end
            end
            LOAD: begin
                pop_c       = 1'b1;
                state_nxt_c = ACK;
            end
            ACK: begin
                if (cnt_busy) begin
                    state_nxt_c = SERV;
                end else if (ack_cnt) begin
                    state_nxt_c = IDLE;
                end else begin
                    ack_cnt_nxt_c = 1'b1;
                end
            end
            SERV: begin
                if (!cnt_busy) begin
                    state_nxt_c = IDLE;
                end
            end
            default: begin
                state_nxt_c = IDLE;
            end
        endcase
    end

    // Head entry is latched on the edge that enters LOAD and cleared after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld   <= 1'b0;
            dn   <= '0;
            dt   <= '0;
            drop <= 1'b0;
            tkt  <= NUM_SZ'(1);
        end else begin
            ld   <= load_c;
            dn   <= load_c ? head_num_c : '0;
            dt   <= load_c ? head_dt_c : '0;
            drop <= reject_c;
            if (accept_c) begin
                tkt <= tkt_nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_cust_queue.sv
// Directed-vector bench for cust_queue: per-cycle table plus ticket-wrap
// and asynchronous-reset sequences.
module tb_cust_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arr = 1'b0;
    logic [3:0] arr_dt = '0;
    logic       cnt_busy = 1'b0;
    logic       ld;
    logic [3:0] dn;
    logic [3:0] dt;
    logic       full;
    logic       empty;
    logic [3:0] q_cnt;
    logic [3:0] tkt;
    logic       drop;

    int nvec  = 0;
    int nfail = 0;

    cust_queue #(
        .DT_SZ  (4),
        .NUM_SZ (4),
        .DEPTH  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arr      (arr),
        .arr_dt   (arr_dt),
        .cnt_busy (cnt_busy),
        .ld       (ld),
        .dn       (dn),
        .dt       (dt),
        .full     (full),
        .empty    (empty),
        .q_cnt    (q_cnt),
        .tkt      (tkt),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       a;
        logic [3:0] adt;
        logic       b;
        logic       e_ld;
        logic [3:0] e_dn;
        logic [3:0] e_dt;
        logic [3:0] e_q;
        logic [3:0] e_tkt;
        logic       e_drop;
        logic       e_full;
        logic       e_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic a, input logic [3:0] adt,
                                input logic b, input logic e_ld, input logic [3:0] e_dn,
                                input logic [3:0] e_dt, input logic [3:0] e_q,
                                input logic [3:0] e_tkt, input logic e_drop,
                                input logic e_full, input logic e_empty);
        vecs.push_back('{r, a, adt, b, e_ld, e_dn, e_dt, e_q, e_tkt, e_drop, e_full, e_empty});
    endfunction

    function automatic void add_rst();
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %05h want %05h", name, act, exp);
        end
    endtask

    task automatic cycle_in(input logic a, input logic [3:0] adt, input logic b);
        @(negedge clk);
        arr      = a;
        arr_dt   = adt;
        cnt_busy = b;
    endtask

    task automatic wait_ld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({ld, dn, dt, q_cnt, tkt, drop, full, empty});
    endfunction

    initial begin
        bit ok;

        // single arrival, counter idle
        add_rst();
        add(1, 1, 3, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 1, 2, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1);
        add(1, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1);

        // three arrivals while busy, FIFO order, ACK timeout path
        add_rst();
        add(1, 1, 3, 1, 0, 0, 0, 1, 2, 0, 0, 0);
        add(1, 1, 6, 1, 0, 0, 0, 2, 3, 0, 0, 0);
        add(1, 1, 2, 1, 0, 0, 0, 3, 4, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 3, 4, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 3, 3, 4, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 2, 4, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 2, 4, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 2, 4, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 2, 4, 0, 0, 0);
        add(1, 0, 0, 0, 1, 2, 6, 2, 4, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        add(1, 0, 0, 0, 1, 3, 2, 1, 4, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1);

        // fill to DEPTH, overflow drop, push accepted alongside pop
        add_rst();
        for (int i = 1; i <= 8; i++) begin
            add(1, 1, 4'(i), 1, 0, 0, 0, 4'(i), 4'(i + 1), 0, (i == 8), 0);
        end
        add(1, 1, 9, 1, 0, 0, 0, 8, 9, 1, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0, 8, 9, 0, 1, 0);
        add(1, 0, 0, 0, 1, 1, 1, 8, 9, 0, 1, 0);
        add(1, 1, 10, 0, 0, 0, 0, 8, 10, 0, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0, 8, 10, 0, 1, 0);

        // zero service time rejected
        add_rst();
        add(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
        add(1, 1, 5, 1, 0, 0, 0, 1, 2, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 1, 2, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0);

        // reset while serving with four waiting, then fresh arrival
        add_rst();
        for (int i = 1; i <= 5; i++) begin
            add(1, 1, 4'(i), 1, 0, 0, 0, 4'(i), 4'(i + 1), 0, 0, 0);
        end
        add(1, 0, 0, 0, 1, 1, 1, 5, 6, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 4, 6, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 4, 6, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 4, 6, 0, 0, 0);
        add_rst();
        for (int i = 0; i < 4; i++) begin
            add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        end
        add(1, 1, 7, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 7, 1, 2, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n    = vecs[i].r;
            arr      = vecs[i].a;
            arr_dt   = vecs[i].adt;
            cnt_busy = vecs[i].b;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), outs(),
                  32'({vecs[i].e_ld, vecs[i].e_dn, vecs[i].e_dt, vecs[i].e_q,
                       vecs[i].e_tkt, vecs[i].e_drop, vecs[i].e_full, vecs[i].e_empty}));
        end

        // ticket wrap: issue 14 tickets one at a time, then 15 and 1
        @(negedge clk);
        rst_n = 1'b0;
        arr = 1'b0;
        cnt_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 14; r++) begin
            cycle_in(1, 4'd1, 0);
            for (int k = 0; k < 4; k++) begin
                cycle_in(0, 4'd0, 0);
            end
        end
        @(negedge clk);
        check("tkt_before_wrap", 32'(tkt), 32'd15);
        cycle_in(1, 4'd2, 1);
        cycle_in(1, 4'd3, 1);
        cycle_in(0, 4'd0, 0);
        wait_ld(ok);
        if (!ok) check("ld_timeout_a", 32'(ok), 32'd1);
        else check("wrap_first", 32'({dn, dt}), 32'({4'd15, 4'd2}));
        check("tkt_after_wrap", 32'(tkt), 32'd2);
        wait_ld(ok);
        if (!ok) check("ld_timeout_b", 32'(ok), 32'd1);
        else check("wrap_second", 32'({dn, dt}), 32'({4'd1, 4'd3}));

        // reset takes effect without waiting for a clock edge
        cycle_in(1, 4'd5, 1);
        cycle_in(0, 4'd0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", outs(), 32'({1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
